// File: rtl/mod_reconstruct.sv
// mod_reconstruct
// ---------------------------------------------------------------------------
// Sequential inverse of the modulo/divide unit: rebuilds the dividend
// a = q*b + r with an N-step shift-add multiplier and flags results that
// overflow N bits (ovf) or carry an inconsistent remainder (inv).
//
// Handshake: start is accepted in IDLE or DONE; busy is high while the N
// iterations run; done pulses for one cycle when a/ovf/inv become valid.
// Results are held until the next DONE.
//
// Build option: define MOD_RECON_CHECK_EN to compile in the remainder
// consistency comparator (b == 0 or r >= b). Without it, inv is tied to 0
// and everything else is unchanged.
// ---------------------------------------------------------------------------
module mod_reconstruct #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] b,
    input  logic [N-1:0] q,
    input  logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] a,
    output logic         ovf,
    output logic         inv
);

    // Count has to hold 0..N-1; one extra bit of headroom keeps N = 2^k safe.
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic [2*N-1:0]  acc_q;      // running sum, starts at zero-extended r
    logic [2*N-1:0]  mcand_q;    // b shifted left once per iteration
    logic [N-1:0]    qsh_q;      // quotient shifted right once per iteration
    logic            inv_lat_q;  // inconsistency flag captured at start

    logic            busy_q;
    logic            done_q;
    logic [N-1:0]    a_q;
    logic            ovf_q;
    logic            inv_q;

    logic [2*N-1:0]  acc_d;      // accumulator after this cycle's add
    logic            inv_cond_d; // inconsistency of the operands on the bus
    logic            last_iter_s;
    logic            accept_s;

    // Accumulator next value: add the shifted multiplicand when the current q bit is set.
    always_comb begin
        acc_d = acc_q;
        if (qsh_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Remainder consistency check on the incoming operands (optional comparator).
    always_comb begin
        inv_cond_d = 1'b0;
`ifdef MOD_RECON_CHECK_EN
        if ((b == {N{1'b0}}) || (r >= b)) begin
            inv_cond_d = 1'b1;
        end else begin
            inv_cond_d = 1'b0;
        end
`else
        inv_cond_d = 1'b0;
`endif
    end

    // Decode of the final iteration and of an acceptable start request.
    always_comb begin
        last_iter_s = 1'b0;
        accept_s    = 1'b0;
        if (count_q == CW'(N - 1)) begin
            last_iter_s = 1'b1;
        end else begin
            last_iter_s = 1'b0;
        end
        if (start && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Control FSM with datapath and registered outputs; reset aborts any run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= {CW{1'b0}};
            acc_q     <= {(2*N){1'b0}};
            mcand_q   <= {(2*N){1'b0}};
            qsh_q     <= {N{1'b0}};
            inv_lat_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            a_q       <= {N{1'b0}};
            ovf_q     <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (accept_s) begin
                        // Latch operands and seed the shift-add datapath.
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        count_q   <= {CW{1'b0}};
                        acc_q     <= {{N{1'b0}}, r};
                        mcand_q   <= {{N{1'b0}}, b};
                        qsh_q     <= q;
                        inv_lat_q <= inv_cond_d;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // start is ignored here; operands stay as latched.
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    qsh_q   <= qsh_q >> 1;
                    count_q <= count_q + CW'(1);
                    if (last_iter_s) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        a_q     <= acc_d[N-1:0];
                        ovf_q   <= |acc_d[2*N-1:N];
                        inv_q   <= inv_lat_q;
                    end else begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign a    = a_q;
    assign ovf  = ovf_q;
    assign inv  = inv_q;

endmodule

// File: tb/tb_mod_reconstruct.sv
// Self-checking bench for mod_reconstruct (N = 4): table of directed vectors
// plus hand-written back-to-back, start-during-RUN and reset-abort sequences.
module tb_mod_reconstruct;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         busy;
    logic         done;
    logic [N-1:0] a;
    logic         ovf;
    logic         inv;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic [3:0] exp_a;
        logic       exp_ovf;
        logic       exp_inv_chk; // inv expected when the comparator is compiled in
    } vec_t;

    vec_t vecs [10];

    mod_reconstruct #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .a     (a),
        .ovf   (ovf),
        .inv   (inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_inv(input logic chk_val);
`ifdef MOD_RECON_CHECK_EN
        return chk_val;
`else
        return 1'b0 & chk_val;
`endif
    endfunction

    // Drive start for one edge, leave the bench #1 after the accepting edge.
    task automatic start_op(input logic [3:0] bb, input logic [3:0] qq, input logic [3:0] rr);
        @(negedge clk);
        start = 1'b1;
        b = bb;
        q = qq;
        r = rr;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count rising edges until done, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string name, input logic [3:0] ea,
                                input logic eo, input logic ei);
        chk({name, ".a"}, {28'd0, a}, {28'd0, ea});
        chk({name, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
        chk({name, ".inv"}, {31'd0, inv}, {31'd0, ei});
        chk({name, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    // Full single operation including latency and post-done hold checks.
    task automatic run_op(input string name, input logic [3:0] bb, input logic [3:0] qq,
                          input logic [3:0] rr, input logic [3:0] ea, input logic eo,
                          input logic ei);
        int cyc;
        start_op(bb, qq, rr);
        chk({name, ".busy_after_start"}, {31'd0, busy}, 32'd1);
        wait_done(cyc);
        chk({name, ".latency"}, cyc, N);
        check_result(name, ea, eo, ei);
        @(posedge clk);
        #1;
        chk({name, ".done_one_cycle"}, {31'd0, done}, 32'd0);
        chk({name, ".a_hold"}, {28'd0, a}, {28'd0, ea});
    endtask

    initial begin
        int cyc;
        int done_seen;
        checks = 0;
        errors = 0;

        //          b      q      r      a      ovf   inv(check)
        vecs[0] = '{4'hA, 4'h1, 4'h3, 4'hD, 1'b0, 1'b0}; // 10*1+3 = 13
        vecs[1] = '{4'h3, 4'h2, 4'h2, 4'h8, 1'b0, 1'b0}; // 3*2+2 = 8
        vecs[2] = '{4'hF, 4'hF, 4'h0, 4'h1, 1'b1, 1'b0}; // 225 mod 16
        vecs[3] = '{4'h3, 4'h1, 4'h3, 4'h6, 1'b0, 1'b1}; // r == b
        vecs[4] = '{4'h0, 4'h5, 4'h2, 4'h2, 1'b0, 1'b1}; // b == 0
        vecs[5] = '{4'h2, 4'h4, 4'h1, 4'h9, 1'b0, 1'b0}; // 2*4+1 = 9
        vecs[6] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1}; // all zero
        vecs[7] = '{4'hF, 4'h0, 4'hF, 4'hF, 1'b0, 1'b1}; // r == b, q == 0
        vecs[8] = '{4'h1, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1}; // 16 exactly
        vecs[9] = '{4'h7, 4'h2, 4'h3, 4'h1, 1'b1, 1'b0}; // 17

        rst   = 1'b1;
        start = 1'b0;
        b     = 4'h0;
        q     = 4'h0;
        r     = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.a", {28'd0, a}, 32'd0);
        chk("reset.ovf", {31'd0, ovf}, 32'd0);
        chk("reset.inv", {31'd0, inv}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].b, vecs[i].q, vecs[i].r,
                   vecs[i].exp_a, vecs[i].exp_ovf, exp_inv(vecs[i].exp_inv_chk));
        end

        // Back-to-back: second start issued during the first DONE cycle.
        start_op(4'h2, 4'h4, 4'h1);
        wait_done(cyc);
        chk("b2b.first_latency", cyc, N);
        check_result("b2b.first", 4'h9, 1'b0, 1'b0);
        start = 1'b1;
        b = 4'h6;
        q = 4'h2;
        r = 4'h3;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b.busy_restart", {31'd0, busy}, 32'd1);
        chk("b2b.done_low", {31'd0, done}, 32'd0);
        chk("b2b.a_hold_in_run", {28'd0, a}, 32'd9);
        wait_done(cyc);
        chk("b2b.gap", cyc + 1, N + 1);
        check_result("b2b.second", 4'hF, 1'b0, 1'b0);

        // start during RUN with other operands is ignored.
        start_op(4'h3, 4'h3, 4'h1);            // 3*3+1 = 10
        @(negedge clk);
        start = 1'b1;
        b = 4'hF;
        q = 4'hF;
        r = 4'hE;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        wait_done(cyc);
        chk("run_start.latency", cyc + 2, N);
        check_result("run_start", 4'hA, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("run_start.no_restart", {31'd0, busy}, 32'd0);

        // Produce a nonzero held result, then abort a run with reset.
        run_op("pre_abort", 4'h7, 4'h2, 4'h3, 4'h1, 1'b1, 1'b0);
        start_op(4'h5, 4'h3, 4'h1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.a", {28'd0, a}, 32'd0);
        chk("abort.ovf", {31'd0, ovf}, 32'd0);
        chk("abort.inv", {31'd0, inv}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        chk("abort.no_done", done_seen, 0);
        run_op("after_abort", 4'h5, 4'h2, 4'h4, 4'hE, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
